// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, opcode field position, PC step.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_HI  = 31;
  localparam int unsigned OPC_LO  = 28;
  localparam int unsigned OPC_W   = OPC_HI - OPC_LO + 1;
  localparam int unsigned PC_STEP = 4;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_RST   = 2'd0;
  localparam fsm_state_t ST_FETCH = 2'd1;
  localparam fsm_state_t ST_ISSUE = 2'd2;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: jump over taken bne-branch over sequential step; redirect targets word-aligned.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic              branch,
  input  logic              zero,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] pc_next_c
);

  // Sequential step wraps naturally at ADDR_W bits.
  always_comb begin
    pc_next_c = pc + ADDR_W'(PC_STEP);
    if (jump) begin
      pc_next_c = {jump_addr[ADDR_W-1:2], 2'b00};
    end else if (branch && !zero) begin
      pc_next_c = {branch_addr[ADDR_W-1:2], 2'b00};
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch from imem, valid/ready issue to decode.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                Clk,
  input  logic                Rst_n,
  output logic                Imem_Req,
  output logic [ADDR_W-1:0]   Imem_Addr,
  input  logic                Imem_Ack,
  input  logic [INSTR_W-1:0]  Imem_Rdata,
  output logic                Instr_Valid,
  input  logic                Instr_Ready,
  output logic [INSTR_W-1:0]  Instr,
  output logic [OPC_W-1:0]    Opcode,
  output logic [ADDR_W-1:0]   PC,
  input  logic                Jump,
  input  logic                Branch,
  input  logic                Zero,
  input  logic [ADDR_W-1:0]   Jump_Addr,
  input  logic [ADDR_W-1:0]   Branch_Addr,
  input  logic                Stall
);

  fsm_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               captured_q, captured_d;
  logic               imem_req_q, imem_req_d;
  logic               instr_valid_q, instr_valid_d;

  logic               ack_c;
  logic               issue_c;
  logic [ADDR_W-1:0]  pc_next_c;

  // A word already held under stall is not overwritten by later acks.
  assign ack_c   = Imem_Ack & imem_req_q & ~captured_q;
  assign issue_c = instr_valid_q & Instr_Ready & ~Stall;

  pc_next_sel #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_sel (
    .pc          (pc_q),
    .jump        (Jump),
    .branch      (Branch),
    .zero        (Zero),
    .jump_addr   (Jump_Addr),
    .branch_addr (Branch_Addr),
    .pc_next_c   (pc_next_c)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_RST;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      captured_q    <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      captured_q    <= captured_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Next state; handshake outputs are registered copies of the next state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    captured_d = captured_q;

    case (state_q)
      ST_RST: begin
        if (!Stall) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (ack_c) begin
          instr_d = Imem_Rdata;
        end
        if (ack_c || captured_q) begin
          if (Stall) begin
            captured_d = 1'b1;
          end else begin
            captured_d = 1'b0;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (issue_c) begin
          pc_d    = pc_next_c;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d    = ST_RST;
        captured_d = 1'b0;
      end
    endcase

    imem_req_d    = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_ISSUE);
  end

  assign Imem_Req    = imem_req_q;
  assign Imem_Addr   = pc_q;
  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign Opcode      = instr_q[OPC_HI:OPC_LO];
  assign Instr_Valid = instr_valid_q;

endmodule
